// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the memory stage (master) and data memory (slave).
// req/ready handshake; rdata is valid in the cycle ready is high for loads.
interface mem_stage_if #(
  parameter int ADDR_W = 64
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [63:0]       dmem_wdata;
  logic [7:0]        dmem_wmask;
  logic              dmem_ready;
  logic [63:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory stage: issues loads/stores on the dmem port, extends load data, fills WB latches.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag WB_MISALIGN.
module mem_stage #(
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_V,
  input  logic [31:0]        MEM_IR,
  input  logic [63:0]        MEM_PC,
  input  logic [63:0]        MEM_ALU_RESULT,
  input  logic [63:0]        MEM_SR2,
  input  logic [63:0]        MEM_CSRFD,
  input  logic [63:0]        MEM_RFD,
  input  logic               MEM_ECALL,
  output logic               MEM_stall,
  mem_stage_if.master        dmem,
  output logic               WB_V,
  output logic [31:0]        WB_IR,
  output logic [63:0]        WB_PC,
  output logic [63:0]        WB_DATA,
  output logic [63:0]        WB_CSRFD,
  output logic [63:0]        WB_RFD,
  output logic               WB_ECALL,
  output logic               WB_MISALIGN
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [63:0] rbuf;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [2:0]  addr_lo;
  logic        is_load, is_store, is_jump, is_mem;
  logic        go_req, wb_load, wb_misalign_nxt;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;
  logic [63:0] ld_data, wb_data_nxt;
  logic        unused_ir;

  assign opcode   = MEM_IR[6:0];
  assign funct3   = MEM_IR[14:12];
  assign addr_lo  = MEM_ALU_RESULT[2:0];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_jump  = (opcode == 7'b1101111) || (opcode == 7'b1100111);
  assign is_mem   = MEM_V && (is_load || is_store);
  assign unused_ir = ^{MEM_IR[31:15], MEM_IR[11:7]};

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'd1:    misalign = addr_lo[0];
      2'd2:    misalign = |addr_lo[1:0];
      2'd3:    misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end
  // A misaligned op retires through WB in one cycle without touching the bus.
  assign wb_misalign_nxt = (state == S_IDLE) && is_mem && misalign;
  assign go_req          = (state == S_IDLE) && is_mem && !misalign;
  assign MEM_stall       = is_mem && !misalign && (state != S_DONE);
`else
  assign wb_misalign_nxt = 1'b0;
  assign go_req          = (state == S_IDLE) && is_mem;
  assign MEM_stall       = is_mem && (state != S_DONE);
`endif

  assign wb_load = ((state == S_IDLE) && !go_req) || (state == S_DONE);

  // Request fields come straight from the MEM latch, which is frozen by MEM_stall.
  assign dmem.dmem_req  = (state == S_REQ);
  assign dmem.dmem_we   = is_store;
  assign dmem.dmem_addr = {MEM_ALU_RESULT[ADDR_W-1:3], 3'b000};

  always_comb begin
    dmem.dmem_wmask = 8'hFF;
    dmem.dmem_wdata = MEM_SR2;
    case (funct3[1:0])
      2'd0: begin
        dmem.dmem_wmask = 8'b1 << addr_lo;
        dmem.dmem_wdata = {8{MEM_SR2[7:0]}};
      end
      2'd1: begin
        dmem.dmem_wmask = 8'b11 << {addr_lo[2:1], 1'b0};
        dmem.dmem_wdata = {4{MEM_SR2[15:0]}};
      end
      2'd2: begin
        dmem.dmem_wmask = 8'hF << {addr_lo[2], 2'b00};
        dmem.dmem_wdata = {2{MEM_SR2[31:0]}};
      end
      default: begin
        dmem.dmem_wmask = 8'hFF;
        dmem.dmem_wdata = MEM_SR2;
      end
    endcase
  end

  assign ld_b = rbuf[{addr_lo, 3'b000} +: 8];
  assign ld_h = rbuf[{addr_lo[2:1], 4'b0000} +: 16];
  assign ld_w = rbuf[{addr_lo[2], 5'b00000} +: 32];

  always_comb begin
    ld_data = rbuf;
    case (funct3[1:0])
      2'd0:    ld_data = funct3[2] ? {56'd0, ld_b} : {{56{ld_b[7]}}, ld_b};
      2'd1:    ld_data = funct3[2] ? {48'd0, ld_h} : {{48{ld_h[15]}}, ld_h};
      2'd2:    ld_data = funct3[2] ? {32'd0, ld_w} : {{32{ld_w[31]}}, ld_w};
      default: ld_data = rbuf;
    endcase
  end

  always_comb begin
    wb_data_nxt = MEM_ALU_RESULT;
    if (is_load && !wb_misalign_nxt) wb_data_nxt = ld_data;
    else if (is_jump)                wb_data_nxt = MEM_PC + 64'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rbuf        <= '0;
      WB_V        <= 1'b0;
      WB_IR       <= '0;
      WB_PC       <= RESET_PC;
      WB_DATA     <= '0;
      WB_CSRFD    <= '0;
      WB_RFD      <= '0;
      WB_ECALL    <= 1'b0;
      WB_MISALIGN <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (go_req) state <= S_REQ;
        S_REQ: begin
          if (dmem.dmem_ready) begin
            rbuf  <= dmem.dmem_rdata;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (wb_load) begin
        WB_V        <= MEM_V;
        WB_IR       <= MEM_IR;
        WB_PC       <= MEM_PC;
        WB_DATA     <= wb_data_nxt;
        WB_CSRFD    <= MEM_CSRFD;
        WB_RFD      <= MEM_RFD;
        WB_ECALL    <= MEM_ECALL;
        WB_MISALIGN <= wb_misalign_nxt;
      end
    end
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- RV64 memory pipeline stage. Consumes the MEM_* latch set produced by execute and issues load/store transactions to a 64-bit data-memory port using a req/ready handshake.
- Extracts and extends load data, then registers results into the WB_* latch set for writeback.
- Drives MEM_stall back to execute while a memory access is outstanding.

Parameters:
- ADDR_W, 64, width of dmem_addr.
- RESET_PC, 64'd0, value loaded into WB_PC on reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
MEM_V  in  1  MEM latch valid
MEM_IR  in  32  instruction
MEM_PC  in  64  instruction PC
MEM_ALU_RESULT  in  64  ALU result / effective address
MEM_SR2  in  64  store data
MEM_CSRFD  in  64  CSR destination value, passed through
MEM_RFD  in  64  CSR result, passed through
MEM_ECALL  in  1  ecall flag, passed through
MEM_stall  out  1  freeze execute/upstream latches (combinational)
dmem_req  out  1  request valid
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  doubleword-aligned address ({addr[ADDR_W-1:3],3'b0})
dmem_wdata  out  64  store data, lane-replicated
dmem_wmask  out  8  byte enables
dmem_ready  in  1  request accepted; for loads, dmem_rdata is valid this cycle
dmem_rdata  in  64  aligned doubleword read data
WB_V, WB_IR, WB_PC, WB_DATA, WB_CSRFD, WB_RFD, WB_ECALL  out  1/32/64/64/64/64/1  writeback latch set
WB_MISALIGN  out  1  misaligned-access flag

Behaviour:
- Opcode decode from MEM_IR[6:0]:
  - LOAD 0000011: funct3 0=LB, 1=LH, 2=LW, 3=LD, 4=LBU, 5=LHU, 6=LWU.
  - STORE 0100011: funct3 0=SB, 1=SH, 2=SW, 3=SD.
  - is_mem = MEM_V & (LOAD | STORE). Load funct3=7 is treated as LD.
- FSM states IDLE, REQ, DONE. Reset: state=IDLE, dmem_req=0, all WB_* =0, WB_PC=RESET_PC.
- IDLE:
  - If is_mem, go to REQ. WB latches hold.
  - Otherwise load WB latches this edge (1-cycle pass-through).
- REQ:
  - dmem_req=1. Address, wdata, wmask and we are held stable from the MEM latch.
  - On dmem_ready=1, capture dmem_rdata into rbuf and go to DONE. Otherwise stay in REQ indefinitely.
- DONE: load WB latches from the MEM latch and rbuf, then go to IDLE.
- MEM_stall = is_mem & (state != DONE). Upstream therefore advances on the same edge WB is written.
- Minimum memory-op latency: 3 cycles (IDLE, REQ with ready, DONE).
- Back-to-back memory ops:
  - The new op is seen in IDLE on the cycle after DONE.
  - No request is issued in DONE.
- Load data path:
  - Lane selected by addr[2:0] (byte), addr[2:1] (half), addr[2] (word).
  - LB/LH/LW sign-extend to 64. LBU/LHU/LWU zero-extend.
- Store data path:
  - wdata replicates SR2 low bits across all lanes.
  - wmask:
    - SB: 8'b1<<addr[2:0]
    - SH: 8'b11<<{addr[2:1],1'b0}
    - SW: 8'hF<<{addr[2],2'b0}
    - SD: 8'hFF
- WB_DATA:
  - load: extended data
  - JAL 1101111 / JALR 1100111: MEM_PC+4
  - otherwise: MEM_ALU_RESULT
  - store: don't-care, driven as MEM_ALU_RESULT.
- MEM_V=0 in IDLE: WB_V<=0 and other WB fields still load. No request is issued.
- Reset in REQ: the transaction is abandoned. dmem_req=0 from the next cycle. A dmem_ready arriving after reset is ignored in IDLE.
- dmem_ready is ignored in IDLE and DONE.
- Misaligned: addr[0]!=0 for H, addr[1:0]!=0 for W, addr[2:0]!=0 for D.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A misaligned is_mem op in IDLE issues no request and does not enter REQ.
  - MEM_stall=0 that cycle.
  - WB latches load with WB_V=MEM_V, WB_MISALIGN=1, WB_DATA=MEM_ALU_RESULT (the faulting address).
  - WB_MISALIGN=0 for all other ops.
- Undefined:
  - WB_MISALIGN tied 0.
  - Misaligned accesses proceed normally, with offset bits beyond natural alignment ignored (address aligned down).

Test Plan:
- Reset then MEM_V=0 -> WB_V=0, dmem_req=0, MEM_stall=0, WB_PC=RESET_PC.
- ADD, MEM_ALU_RESULT=0x1234 -> next edge WB_V=1, WB_DATA=0x1234, MEM_stall never high.
- LB addr=0x1003, dmem_rdata=0x0000_0000_8000_0000, ready on first REQ cycle -> MEM_stall high 2 cycles, WB_DATA=0xFFFF_FFFF_FFFF_FF80 at DONE edge.
- SH addr=0x2006, SR2=0xABCD, ready delayed 4 cycles -> dmem_req high 5 cycles, wmask=8'hC0, wdata[63:48]=0xABCD, addr=0x2000, stable throughout.
- JAL MEM_PC=0x100 -> WB_DATA=0x104. LWU addr=0x8 with rdata=0xFFFF_FFFF_0000_0000 -> WB_DATA=0x0.
- LW addr=0x2: with MISALIGN_TRAP_EN -> no dmem_req, WB_MISALIGN=1, WB_DATA=0x2. Without -> access issued at 0x0, lane 0 returned. Plus reset asserted mid-REQ -> dmem_req=0 next cycle, WB_V=0.
